req_encode_8_3: RTL and testbench
=================================

Name: req_encode_8_3

Overview:
- Sequential 8-to-3 encoder, the inverse of the team's 3-to-8 one-hot decoder.
- Collects one-hot or multi-hot request bits into a pending set.
- Emits one binary index per transfer over a valid/ready output, lowest index first by default.
- Used by the pipeline wherever a set of flags must be serialised into register or unit indices, for example writeback-pending or exception-source selection.

Parameters:
- N_IN, 8, number of request lines. Must be a power of two, at least 2.
- IDX_W, $clog2(N_IN), width of the encoded index. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_in  input  N_IN  request bits, sampled only when en=1
- en  input  1  request load enable
- idx_out  output  IDX_W  encoded index of the request being presented
- idx_valid  output  1  idx_out holds a valid index
- idx_ready  input  1  consumer accepts idx_out this cycle
- pending  output  N_IN  requests captured but not yet presented
- busy  output  1  idx_valid OR (pending != 0)

Behaviour:
- Reset (synchronous, active-high): pending=0, idx_out=0, idx_valid=0, busy=0, state=EMPTY. On the next edge, reset overrides en, req_in and idx_ready. An index in flight is dropped. Round-robin pointer (if built) returns to N_IN-1.
- Pending update, every cycle: pending_d = (pending_q & ~sel_onehot) | (en ? req_in : 0).
  - Selection uses pending_q only. Bits arriving this cycle are never selected in the same cycle.
  - If req_in[k]=1 arrives while bit k is being selected, bit k stays set. It is a new request and is emitted again later.
  - Re-asserting an already-pending bit merges with it. There is no count and no overflow.
- Output FSM, two states:
  - EMPTY (idx_valid=0). If pending_q != 0: select, load idx_out, clear the selected bit, go to FULL.
  - FULL (idx_valid=1). If idx_ready=1 and pending_q != 0: load the next index, stay FULL. This gives back-to-back transfers, one per cycle.
  - FULL, idx_ready=1 and pending_q == 0: go to EMPTY. idx_out holds its old value.
  - FULL, idx_ready=0: idx_out and idx_valid hold stable; pending keeps accumulating.
- sel_onehot is nonzero only when the slot is loading (EMPTY, or FULL with idx_ready=1) and pending_q != 0.
- Latency: en=1 at edge N, pending visible after edge N, idx_valid=1 after edge N+1. Two cycles, request to valid.
- Priority, fixed mode: lowest set index wins.
- Throughput: one index per cycle while idx_ready=1.
- All outputs are registered except busy, which is a combinational OR of registers.
- en=1 with req_in=0 is a no-op.

Optional Feature:
- Macro: REQ_ENCODE_ROUND_ROBIN_EN.
- Defined: a registered pointer last_q (reset N_IN-1) records the last emitted index. Selection searches upward from last_q+1, modulo N_IN. last_q updates on every load.
- Not defined: fixed lowest-index priority. No pointer register exists.

Decomposition:
- Shared package req_encode_pkg holds:
  - N_IN_DEF=8 and IDX_W_DEF=3
  - typedef state_t {EMPTY, FULL}
  - typedef idx_t, logic [IDX_W_DEF-1:0]
- One natural sub-module: prio_enc_8_3, combinational. It takes an N_IN vector and a rotate base, and outputs index, onehot and any. It is the structural mirror of the decoder.
- Fixed mode ties the rotate base to 0.

Test Plan:
- Reset: drive req_in=8'hFF, en=1, reset=1 for 2 cycles -> pending=0, idx_valid=0, busy=0. Deassert reset with en=0 -> outputs stay 0.
- Single request: en=1, req_in=8'b0010_0000 for one cycle, idx_ready=1 -> idx_valid=1 two cycles later with idx_out=5, then idx_valid=0, pending=0.
- Multi-hot drain, fixed mode: req_in=8'b1001_0110, idx_ready=1 -> idx_out sequence 1,2,4,7 on consecutive cycles, then idx_valid drops.
- Backpressure: req_in=8'b0000_1100, idx_ready=0 for 5 cycles -> idx_out=2 stable, pending=8'b0000_1000. Raise idx_ready -> idx_out=3 next cycle, then empty.
- Simultaneous re-arm: while index 3 is being loaded, en=1 with req_in=8'b0000_1000 -> index 3 is emitted twice in total and pending ends at 0.
- Round-robin (REQ_ENCODE_ROUND_ROBIN_EN defined): emit index 2, then load req_in=8'b0000_0101 -> order is 0 then 2 (pointer wraps from 2 to 0). Without the macro -> 0 then 2, same order by index. Then repeat with last=0 and req_in=8'b0000_0011 -> 1 then 0 with RR, 0 then 1 fixed.

Source files
------------

// File: rtl/req_encode_pkg.sv
// Shared types and defaults for the sequential 8-to-3 request encoder.
package req_encode_pkg;

    localparam int N_IN_DEF  = 8;
    localparam int IDX_W_DEF = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef logic [IDX_W_DEF-1:0] idx_t;

endpackage

// File: rtl/req_encode_8_3_prio.sv
// Rotating priority encoder: first set bit of i_vec at or above i_base, wrapping modulo N_IN.
module prio_enc_8_3 #(
    parameter int N_IN  = 8,
    parameter int IDX_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  i_vec,
    input  logic [IDX_W-1:0] i_base,
    output logic [IDX_W-1:0] o_idx,
    output logic [N_IN-1:0]  o_onehot,
    output logic             o_any
);

    logic [IDX_W-1:0] w_cand;

    // Scan from the farthest offset down so the nearest set bit to i_base wins last.
    always_comb begin
        o_idx  = {IDX_W{1'b0}};
        o_any  = 1'b0;
        w_cand = {IDX_W{1'b0}};
        for (int k = N_IN - 1; k >= 0; k--) begin
            w_cand = i_base + IDX_W'(k);
            if (i_vec[w_cand]) begin
                o_idx = w_cand;
                o_any = 1'b1;
            end else begin
                o_idx = o_idx;
                o_any = o_any;
            end
        end
    end

    assign o_onehot = o_any ? (N_IN'(1) << o_idx) : {N_IN{1'b0}};

endmodule

// File: rtl/req_encode_8_3.sv
// Sequential 8-to-3 encoder: serialises a pending request set into indices over valid/ready.
// Optional round-robin selection is built when REQ_ENCODE_ROUND_ROBIN_EN is defined.
module req_encode_8_3
    import req_encode_pkg::*;
#(
    parameter  int N_IN  = N_IN_DEF,
    localparam int IDX_W = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IN-1:0]  req_in,
    input  logic             en,
    output logic [IDX_W-1:0] idx_out,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [N_IN-1:0]  pending,
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_IN-1:0]  r_pending;
    logic [N_IN-1:0]  w_pending_nxt;
    logic [N_IN-1:0]  w_sel_onehot;
    logic [N_IN-1:0]  w_enc_onehot;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_enc_idx;
    logic [IDX_W-1:0] w_base;
    logic             w_enc_any;
    logic             w_load;
    logic             w_take;

`ifdef REQ_ENCODE_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_last;

    // Pointer to the most recently loaded index; search resumes just above it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= IDX_W'(N_IN - 1);
        end else if (w_take) begin
            r_last <= w_enc_idx;
        end else begin
            r_last <= r_last;
        end
    end

    assign w_base = r_last + IDX_W'(1);
`else
    assign w_base = {IDX_W{1'b0}};
`endif

    prio_enc_8_3 #(
        .N_IN  (N_IN),
        .IDX_W (IDX_W)
    ) u_prio (
        .i_vec    (r_pending),
        .i_base   (w_base),
        .o_idx    (w_enc_idx),
        .o_onehot (w_enc_onehot),
        .o_any    (w_enc_any)
    );

    // The output slot can take a new index when empty or when the current one is accepted.
    assign w_load       = (r_state == EMPTY) | idx_ready;
    assign w_take       = w_load & w_enc_any;
    assign w_sel_onehot = w_take ? w_enc_onehot : {N_IN{1'b0}};

    // Next-state logic for the output slot.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: begin
                if (w_take) begin
                    w_state_nxt = FULL;
                end else begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (idx_ready && !w_enc_any) begin
                    w_state_nxt = EMPTY;
                end else begin
                    w_state_nxt = FULL;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    // New arrivals are OR-ed after clearing, so a bit re-armed while selected stays set.
    always_comb begin
        w_pending_nxt = r_pending & ~w_sel_onehot;
        if (en) begin
            w_pending_nxt = w_pending_nxt | req_in;
        end else begin
            w_pending_nxt = w_pending_nxt;
        end
    end

    // State, pending set and presented index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= EMPTY;
            r_pending <= {N_IN{1'b0}};
            r_idx     <= {IDX_W{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            if (w_take) begin
                r_idx <= w_enc_idx;
            end else begin
                r_idx <= r_idx;
            end
        end
    end

    assign idx_out   = r_idx;
    assign idx_valid = (r_state == FULL);
    assign pending   = r_pending;
    assign busy      = idx_valid | (|r_pending);

endmodule

// File: tb/tb_req_encode_8_3.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle model.
module tb_req_encode_8_3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req_in = 8'h00;
    logic       en = 1'b0;
    logic [2:0] idx_out;
    logic       idx_valid;
    logic       idx_ready = 1'b0;
    logic [7:0] pending;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit m_pend[8];
    bit m_valid;
    int m_idx;
    int m_last;

    int dut_q[$];
    int exp_q[$];

    req_encode_8_3 dut (
        .clk       (clk),
        .reset     (reset),
        .req_in    (req_in),
        .en        (en),
        .idx_out   (idx_out),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .pending   (pending),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int m_pend_vec();
        int v = 0;
        for (int k = 0; k < 8; k++) if (m_pend[k]) v += (1 << k);
        return v;
    endfunction

    function automatic int pick();
        for (int j = 0; j < 8; j++) begin
            int c;
`ifdef REQ_ENCODE_ROUND_ROBIN_EN
            c = (m_last + 1 + j) % 8;
`else
            c = j;
`endif
            if (m_pend[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_edge(input bit r, input bit e, input logic [7:0] q, input bit y);
        int sel;
        if (r) begin
            for (int k = 0; k < 8; k++) m_pend[k] = 1'b0;
            m_valid = 1'b0;
            m_idx   = 0;
            m_last  = 7;
        end else begin
            sel = -1;
            if (!m_valid || y) sel = pick();
            for (int k = 0; k < 8; k++)
                m_pend[k] = (m_pend[k] && k != sel) || (e && q[k]);
            if (sel >= 0) begin
                m_idx   = sel;
                m_valid = 1'b1;
                m_last  = sel;
            end else if (m_valid && y) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [7:0] q, input bit y);
        @(negedge clk);
        reset = r; en = e; req_in = q; idx_ready = y;
        if (!r && idx_valid && y) dut_q.push_back(int'(idx_out));
        @(posedge clk);
        model_edge(r, e, q, y);
        #1;
        chk("idx_valid", int'(idx_valid), int'(m_valid));
        chk("idx_out", int'(idx_out), m_idx);
        chk("pending", int'(pending), m_pend_vec());
        chk("busy", int'(busy), int'(m_valid || m_pend_vec() != 0));
    endtask

    task automatic drain(input int cycles);
        for (int c = 0; c < cycles; c++) step(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic check_seq(input string tag);
        chk({tag, "_count"}, dut_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < dut_q.size(); i++)
            chk(tag, dut_q[i], exp_q[i]);
        dut_q.delete();
        exp_q.delete();
    endtask

    initial begin
        // Reset with aggressive inputs; reset must win
        step(1'b1, 1'b1, 8'hFF, 1'b1);
        step(1'b1, 1'b1, 8'hFF, 1'b1);
        chk("rst_pending", int'(pending), 0);
        chk("rst_valid", int'(idx_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_idx", int'(idx_out), 0);
        step(1'b0, 1'b0, 8'hFF, 1'b0);
        chk("post_rst_busy", int'(busy), 0);

        // Single request, two-cycle latency
        step(1'b0, 1'b1, 8'b0010_0000, 1'b1);
        chk("single_pend", int'(pending), 8'h20);
        chk("single_valid_n1", int'(idx_valid), 0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("single_valid", int'(idx_valid), 1);
        chk("single_idx", int'(idx_out), 5);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("single_empty", int'(idx_valid), 0);
        chk("single_pend0", int'(pending), 0);
        dut_q.delete();

        // Multi-hot drain, one index per cycle
        step(1'b0, 1'b1, 8'b1001_0110, 1'b1);
        drain(6);
        exp_q = '{1, 2, 4, 7};
        check_seq("multi_seq");
        chk("multi_idle", int'(busy), 0);

        // Backpressure holds the slot while pending accumulates nothing new
        step(1'b0, 1'b1, 8'b0000_1100, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            chk("bp_idx", int'(idx_out), 2);
            chk("bp_pend", int'(pending), 8'h08);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("bp_next", int'(idx_out), 3);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("bp_empty", int'(idx_valid), 0);
        dut_q.delete();

        // Re-arm bit 3 in the cycle it is being selected
        step(1'b0, 1'b1, 8'b0000_1000, 1'b1);
        step(1'b0, 1'b1, 8'b0000_1000, 1'b1);
        chk("rearm_pend", int'(pending), 8'h08);
        drain(4);
        exp_q = '{3, 3};
        check_seq("rearm_seq");
        chk("rearm_pend0", int'(pending), 0);

        // Pointer wrap: emit 2, then {0,2}
        step(1'b0, 1'b1, 8'b0000_0100, 1'b1);
        drain(3);
        dut_q.delete();
        step(1'b0, 1'b1, 8'b0000_0101, 1'b1);
        drain(4);
        exp_q = '{0, 2};
        check_seq("wrap_seq");

        // After emitting 0, {0,1} order depends on the selection mode
        step(1'b0, 1'b1, 8'b0000_0001, 1'b1);
        drain(3);
        dut_q.delete();
        step(1'b0, 1'b1, 8'b0000_0011, 1'b1);
        drain(4);
`ifdef REQ_ENCODE_ROUND_ROBIN_EN
        exp_q = '{1, 0};
`else
        exp_q = '{0, 1};
`endif
        check_seq("order_seq");

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
                 8'($urandom), ($urandom_range(0, 3) != 0));
        end
        drain(12);
        chk("final_idle", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
